// File: rtl/row_writeback.sv
// Serialises one next-state row per handshake into WORD_W-bit BRAM writes,
// ping-ponging between two frame banks that swap when the last row lands.
module row_writeback #(
    parameter int ROW_W     = 1280,
    parameter int WORD_W    = 32,
    parameter int NUM_ROWS  = 720,
    parameter int ROW_IDX_W = 10,
    parameter int ADDR_W    = 16
) (
    input  logic                 out_stream_aclk,
    input  logic                 out_stream_aresetn,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [ROW_W-1:0]     row_data,
    input  logic [ROW_IDX_W-1:0] row_idx,
    output logic                 bram_we,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [WORD_W-1:0]    bram_wdata,
    output logic                 write_bank,
    output logic                 display_bank,
    output logic                 frame_done,
    output logic                 row_err
);

    localparam int WPR        = ROW_W / WORD_W;
    localparam int BANK_WORDS = NUM_ROWS * WPR;
    localparam int CNT_W      = $clog2(WPR + 1);

    localparam logic [CNT_W-1:0]     WPR_C     = CNT_W'(WPR);
    localparam logic [ADDR_W-1:0]    WPR_A     = ADDR_W'(WPR);
    localparam logic [ADDR_W-1:0]    BANK_A    = ADDR_W'(BANK_WORDS);
    localparam logic [ROW_IDX_W-1:0] LAST_IDX  = ROW_IDX_W'(NUM_ROWS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    if (ROW_W % WORD_W != 0) begin : g_bad_row_w
        $error("row_writeback: ROW_W must be a multiple of WORD_W");
    end
    if (longint'(2) * BANK_WORDS > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("row_writeback: ADDR_W too narrow for two frame banks");
    end

    logic [1:0]        state;
    logic [ROW_W-1:0]  shift_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  word_cnt;
    logic              last_q;
    logic [ADDR_W-1:0] next_base;

    always_comb begin
        next_base = (write_bank ? BANK_A : '0) + ADDR_W'(row_idx) * WPR_A;
    end

    always_ff @(posedge out_stream_aclk or negedge out_stream_aresetn) begin
        if (!out_stream_aresetn) begin
            state        <= IDLE;
            row_ready    <= 1'b1;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
            write_bank   <= 1'b0;
            display_bank <= 1'b1;
            frame_done   <= 1'b0;
            row_err      <= 1'b0;
            shift_q      <= '0;
            base_q       <= '0;
            word_cnt     <= '0;
            last_q       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            row_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (row_valid && row_ready) begin
                        if (row_idx <= LAST_IDX) begin
                            // Word 0 is issued on acceptance so writes occupy
                            // the WPR cycles directly after the handshake.
                            bram_we    <= 1'b1;
                            bram_addr  <= next_base;
                            bram_wdata <= row_data[WORD_W-1:0];
                            shift_q    <= row_data >> WORD_W;
                            base_q     <= next_base;
                            last_q     <= (row_idx == LAST_IDX);
                            word_cnt   <= CNT_W'(1);
                            row_ready  <= 1'b0;
                            state      <= WRITE;
                        end else begin
                            row_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (word_cnt == WPR_C) begin
                        bram_we  <= 1'b0;
                        word_cnt <= '0;
                        if (last_q) begin
                            frame_done   <= 1'b1;
                            write_bank   <= ~write_bank;
                            display_bank <= ~display_bank;
                            state        <= DONE;
                        end else begin
                            row_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        bram_addr  <= base_q + ADDR_W'(word_cnt);
                        bram_wdata <= shift_q[WORD_W-1:0];
                        shift_q    <= shift_q >> WORD_W;
                        word_cnt   <= word_cnt + 1'b1;
                    end
                end
                DONE: begin
                    row_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    bram_we   <= 1'b0;
                    row_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
